// File: rtl/anemo_pio_write_arbiter_if.sv
// Avalon-MM write-only bus between the PIO write arbiter and the output PIO slave.
// The master side drives every signal; the slave side only observes.
interface anemo_pio_write_arbiter_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata
    );

    modport slave (
        input address,
        input chipselect,
        input write_n,
        input writedata
    );
endinterface

// File: rtl/anemo_pio_write_arbiter.sv
// Round-robin arbiter sharing the 8-bit output PIO between several hardware
// requesters. Each grant merges the requester's masked bits into a shadow copy
// of the PIO value and issues exactly one registered Avalon write cycle.
module anemo_pio_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 8,
    parameter int PIO_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_mask,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [DATA_W-1:0]         shadow_out,
    anemo_pio_write_arbiter_if.master pio
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    // Registered state
    state_t              r_state;
    logic [DATA_W-1:0]   r_shadow;
    logic [DATA_W-1:0]   r_merged;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_last_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_chipselect;
    logic                r_write_n;
    logic [1:0]          r_address;
    logic [31:0]         r_writedata;

    // Arbitration results
    logic                w_any_req;
    logic [GW-1:0]       w_pick;
    logic [DATA_W-1:0]   w_sel_data;
    logic [DATA_W-1:0]   w_sel_mask;
    int                  w_best;
    int                  w_dist;

    // Next-state values
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_shadow_nxt;
    logic [DATA_W-1:0]   w_merged_nxt;
    logic [GW-1:0]       w_grant_nxt;
    logic [GW-1:0]       w_last_grant_nxt;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic                w_chipselect_nxt;
    logic                w_write_n_nxt;
    logic [31:0]         w_writedata_nxt;

    // Round-robin pick: the requesting index closest after last_grant wins.
    // Distance 0 is last_grant+1, so the previous winner is scanned last.
    always_comb begin
        // NOTE: every variable gets a default before any branch so the block
        // cannot infer a latch on paths that do not assign it.
        w_any_req  = 1'b0;
        w_pick     = '0;
        w_sel_data = '0;
        w_sel_mask = '0;
        w_best     = NUM_REQ;
        w_dist     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_any_req  = 1'b1;
                w_pick     = GW'(i);
                w_sel_data = req_data[i*DATA_W +: DATA_W];
                w_sel_mask = req_mask[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM next-state and next values of the registered Avalon/ack outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_shadow_nxt     = r_shadow;
        w_merged_nxt     = r_merged;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_ack_nxt        = '0;
        w_chipselect_nxt = 1'b0;
        w_write_n_nxt    = 1'b1;
        w_writedata_nxt  = '0;

        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt      = w_pick;
                    w_merged_nxt     = (r_shadow & ~w_sel_mask) | (w_sel_data & w_sel_mask);
                    // Strobe is registered here so it is on the bus during WRITE.
                    w_chipselect_nxt = 1'b1;
                    w_write_n_nxt    = 1'b0;
                    w_writedata_nxt  = 32'(w_merged_nxt);
                    w_state_nxt      = S_WRITE;
                end
            end
            S_WRITE: begin
                w_shadow_nxt = r_merged;
                for (int i = 0; i < NUM_REQ; i++) begin
                    w_ack_nxt[i] = (r_grant == GW'(i));
                end
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_last_grant_nxt = r_grant;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any transaction.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state      <= S_IDLE;
            r_shadow     <= '0;
            r_merged     <= '0;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_ack        <= '0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_address    <= 2'(PIO_ADDR);
            r_writedata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow     <= w_shadow_nxt;
            r_merged     <= w_merged_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_ack        <= w_ack_nxt;
            r_chipselect <= w_chipselect_nxt;
            r_write_n    <= w_write_n_nxt;
            r_address    <= 2'(PIO_ADDR);
            r_writedata  <= w_writedata_nxt;
        end
    end

    assign ack            = r_ack;
    assign busy           = (r_state != S_IDLE);
    assign shadow_out     = r_shadow;
    assign pio.address    = r_address;
    assign pio.chipselect = r_chipselect;
    assign pio.write_n    = r_write_n;
    assign pio.writedata  = r_writedata;

endmodule

// File: tb/tb_anemo_pio_write_arbiter.sv
// Directed bench for the PIO write arbiter: a table of single transactions
// followed by hand-written multi-cycle sequences.
module tb_anemo_pio_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [23:0] req_mask;
    logic [2:0]  ack;
    logic        busy;
    logic [7:0]  shadow_out;

    anemo_pio_write_arbiter_if pio_bus();

    anemo_pio_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .PIO_ADDR (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .ack        (ack),
        .busy       (busy),
        .shadow_out (shadow_out),
        .pio        (pio_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] data;
        logic [23:0] mask;
        int          grant;
        logic [7:0]  wdata;
    } vec_t;

    vec_t tbl[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   g_seq[16];
    int   g_cyc[16];
    int   n_seen;
    int   n_strobe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [2:0] a);
        case (a)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_mask = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction from IDLE: strobe in the next cycle, ack one cycle later.
    task automatic do_txn(input string tag, input logic [2:0] r, input logic [23:0] d,
                          input logic [23:0] m, input int g, input logic [7:0] w);
        logic [2:0] oh;
        oh       = 3'b001 << g;
        req      = r;
        req_data = d;
        req_mask = m;
        @(negedge clk);
        check({tag, " cs"},    32'(pio_bus.chipselect), 32'd1);
        check({tag, " wr_n"},  32'(pio_bus.write_n),    32'd0);
        check({tag, " addr"},  32'(pio_bus.address),    32'd0);
        check({tag, " wdata"}, pio_bus.writedata,       32'(w));
        check({tag, " busy1"}, 32'(busy),               32'd1);
        @(negedge clk);
        check({tag, " ack"},    32'(ack),               32'(oh));
        check({tag, " cs_off"}, 32'(pio_bus.chipselect), 32'd0);
        check({tag, " shadow"}, 32'(shadow_out),        32'(w));
        check({tag, " busy2"},  32'(busy),              32'd1);
        req = '0;
        @(negedge clk);
        check({tag, " ack_off"}, 32'(ack),  32'd0);
        check({tag, " idle"},    32'(busy), 32'd0);
    endtask

    // Holds requests and records each ack; non-persistent requesters drop on ack.
    task automatic hold_reqs(input logic [2:0] r, input int want, input bit persistent);
        int bound;
        bound    = want * 3 + 6;
        n_seen   = 0;
        n_strobe = 0;
        req      = r;
        for (int c = 0; c < bound && n_seen < want; c++) begin
            @(negedge clk);
            if (pio_bus.chipselect && !pio_bus.write_n) n_strobe++;
            if (ack != '0) begin
                g_seq[n_seen] = onehot_idx(ack);
                g_cyc[n_seen] = c;
                n_seen++;
                if (!persistent) req = req & ~ack;
                if (n_seen == want) req = '0;
            end
        end
        check("hold ack count", 32'(n_seen), 32'(want));
        @(negedge clk);
    endtask

    initial begin
        int exp_g;
        int cnt[3];
        int mx;
        int mn;

        // Shadow evolves through the table; grants follow last_grant from reset (2).
        tbl[0] = '{3'b010, 24'h00A500, 24'h00FF00, 1, 8'hA5};
        tbl[1] = '{3'b001, 24'h00000F, 24'h00003C, 0, 8'h8D};
        tbl[2] = '{3'b101, 24'h0000FF, 24'h0F00FF, 2, 8'h80};
        tbl[3] = '{3'b011, 24'h002211, 24'h00F0FF, 0, 8'h11};
        tbl[4] = '{3'b110, 24'h553C00, 24'hFFFF00, 1, 8'h3C};
        tbl[5] = '{3'b100, 24'hFF0000, 24'h000000, 2, 8'h3C};
        tbl[6] = '{3'b111, 24'h9966C3, 24'hFFFF0F, 0, 8'h33};
        tbl[7] = '{3'b001, 24'h000000, 24'h0000FF, 0, 8'h00};

        do_reset();
        check("rst busy",   32'(busy),               32'd0);
        check("rst ack",    32'(ack),                32'd0);
        check("rst cs",     32'(pio_bus.chipselect), 32'd0);
        check("rst wr_n",   32'(pio_bus.write_n),    32'd1);
        check("rst addr",   32'(pio_bus.address),    32'd0);
        check("rst wdata",  pio_bus.writedata,       32'd0);
        check("rst shadow", 32'(shadow_out),         32'd0);

        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].data, tbl[i].mask,
                   tbl[i].grant, tbl[i].wdata);
        end

        // Simultaneous requests after reset: order 0,1,2, acks 3 cycles apart.
        do_reset();
        req_data = 24'h302010;
        req_mask = 24'hFFFFFF;
        hold_reqs(3'b111, 3, 1'b0);
        check("simul g0",      32'(g_seq[0]), 32'd0);
        check("simul g1",      32'(g_seq[1]), 32'd1);
        check("simul g2",      32'(g_seq[2]), 32'd2);
        check("simul gap01",   32'(g_cyc[1] - g_cyc[0]), 32'd3);
        check("simul gap12",   32'(g_cyc[2] - g_cyc[1]), 32'd3);
        check("simul strobes", 32'(n_strobe), 32'd3);
        check("simul shadow",  32'(shadow_out), 32'h30);

        // Fairness: after requester 1, requester 2 is ahead of 0.
        do_txn("serve1", 3'b010, 24'h004400, 24'h00FF00, 1, 8'h44);
        req_data = 24'h0B000A;
        req_mask = 24'hFF00FF;
        hold_reqs(3'b101, 2, 1'b0);
        check("fair first", 32'(g_seq[0]), 32'd2);
        check("fair second", 32'(g_seq[1]), 32'd0);

        // Ten rounds with every requester asking: strict rotation from last grant 0.
        hold_reqs(3'b111, 10, 1'b1);
        exp_g = 0;
        cnt   = '{0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            exp_g = (exp_g + 1) % 3;
            check($sformatf("rr grant%0d", i), 32'(g_seq[i]), 32'(exp_g));
            if (g_seq[i] >= 0 && g_seq[i] < 3) cnt[g_seq[i]]++;
        end
        mx = cnt[0];
        mn = cnt[0];
        for (int i = 1; i < 3; i++) begin
            if (cnt[i] > mx) mx = cnt[i];
            if (cnt[i] < mn) mn = cnt[i];
        end
        check("rr balance", 32'(mx - mn <= 1), 32'd1);
        check("rr strobes", 32'(n_strobe), 32'd10);

        // Reset asserted in the WRITE cycle aborts the transaction.
        req      = 3'b010;
        req_data = 24'h005A00;
        req_mask = 24'h00FF00;
        @(negedge clk);
        check("abort in write", 32'(pio_bus.chipselect), 32'd1);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("abort cs",     32'(pio_bus.chipselect), 32'd0);
        check("abort wr_n",   32'(pio_bus.write_n),    32'd1);
        check("abort shadow", 32'(shadow_out),         32'd0);
        check("abort ack",    32'(ack),                32'd0);
        check("abort busy",   32'(busy),               32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort no ack", 32'(ack), 32'd0);
        do_txn("post_abort", 3'b100, 24'h770000, 24'hFF0000, 2, 8'h77);

        // Late data change and early req drop: latched value written, ack still sent.
        req      = 3'b001;
        req_data = 24'h000012;
        req_mask = 24'h0000FF;
        @(negedge clk);
        check("late wdata", pio_bus.writedata, 32'h12);
        req_data = 24'h0000EE;
        req      = '0;
        @(negedge clk);
        check("late ack",    32'(ack),        32'b001);
        check("late shadow", 32'(shadow_out), 32'h12);
        @(negedge clk);
        check("late ack off", 32'(ack), 32'd0);
        @(negedge clk);
        check("late no rewrite", 32'(pio_bus.chipselect), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/anemo_pio_write_arbiter.md
Name: anemo_pio_write_arbiter

Overview:
- Shares the 8-bit output PIO Avalon-MM slave (address, chipselect, write_n, writedata) between NUM_REQ hardware requesters, e.g. speed display updater, alarm logic and bridge from the processor.
- Each requester asks for a masked bit update. The arbiter merges it into a shadow copy of the PIO value and issues one Avalon write cycle per grant.
- Requesters are served in round-robin order.
- Sits between the requester logic and the PIO slave port in the anemometer SOPC top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 8, PIO output width.
- PIO_ADDR, 0, Avalon register offset of the PIO data register.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held high until the matching ack.
- req_data  in  NUM_REQ*DATA_W  requester i value in bits [i*DATA_W +: DATA_W].
- req_mask  in  NUM_REQ*DATA_W  requester i bit-enable mask; 1 = bit is updated.
- ack  out  NUM_REQ  one-cycle pulse when requester i's write is complete.
- busy  out  1  high in any state other than IDLE.
- shadow_out  out  DATA_W  last value written to the PIO.
- pio_address  out  2  Avalon address.
- pio_chipselect  out  1  Avalon chipselect.
- pio_write_n  out  1  Avalon write strobe, active low.
- pio_writedata  out  32  Avalon write data.

Behaviour:
- Reset values:
  - State = IDLE; shadow = 0, matching the PIO reset value.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - ack = 0, busy = 0, pio_chipselect = 0, pio_write_n = 1.
  - pio_address = PIO_ADDR, pio_writedata = 0.
- Reset dominates every other condition. A reset asserted mid-transaction aborts it: no ack is issued and outputs take reset values on the next edge.
- FSM has three states: IDLE, WRITE, ACK.
- IDLE:
  - If any req bit is high, grant g = the first set index scanning last_grant+1, +2, ... modulo NUM_REQ.
  - Latch merged = (shadow & ~mask_g) | (data_g & mask_g), then go to WRITE.
  - If no req bit is high, stay in IDLE.
- WRITE (exactly one cycle):
  - pio_chipselect = 1, pio_write_n = 0, pio_address = PIO_ADDR.
  - pio_writedata = {zeros, merged}, with upper 32-DATA_W bits = 0.
  - shadow <= merged. Next state ACK.
- ACK (one cycle):
  - ack[g] = 1, all other ack bits 0.
  - last_grant <= g. Next state IDLE.
- Outside WRITE: pio_chipselect = 0 and pio_write_n = 1. Avalon outputs are registered.
- Latency: req first seen high in IDLE at edge n → write strobe during cycle n+1 → ack during cycle n+2 → back in IDLE at n+3.
- Throughput: at most one write per 3 cycles.
- Requests are level-sensitive:
  - A req still high in the IDLE cycle after ack is a new request. Requesters must drop req in the cycle they see ack.
  - req, data and mask are sampled only in IDLE. Changes during WRITE or ACK have no effect on the current transaction.
  - A req dropped after the grant does not abort: the write and the ack still occur.
- A mask of all zeros still performs the write cycle with an unchanged value and acks normally.
- With several simultaneous requests, exactly one is granted per pass. No requester waits more than NUM_REQ-1 other grants.
- Bits of req at or above NUM_REQ do not exist. Only valid indices are scanned.
- shadow_out = shadow at all times.

Test Plan:
- Single request: reset, then req[1]=1, data=0xA5, mask=0xFF.
  - Required: exactly one cycle with chipselect=1, write_n=0, address=0, writedata=0x000000A5.
  - Then ack[1] pulses one cycle later; shadow_out=0xA5; busy is high for 2 cycles.
- Masked merge: shadow=0xA5, then req[0] with data=0x0F, mask=0x3C.
  - Required: writedata=0x0000008D, shadow_out=0x8D.
- Simultaneous requests: req=3'b111, held by each requester until its own ack.
  - Required: grants in order 0,1,2; acks 3 cycles apart; exactly three write strobes.
- Fairness: after requester 1 is served, assert req[0] and req[2] together.
  - Required: 2 is served before 0. Repeat 10 rounds; grant counts must differ by at most 1.
- Reset mid-operation: assert reset during the WRITE cycle.
  - Required: next cycle chipselect=0, write_n=1, shadow_out=0, no ack.
  - Then a fresh req[2] is served normally.
- Late and early changes:
  - Change req_data during the WRITE cycle → the latched value is written.
  - Drop req after the grant → ack still pulses.
  - Send mask=0x00 → a write cycle occurs with writedata equal to the current shadow.
